// File: rtl/pong_pkg.sv
// Shared definitions for the Pong button path.
// Holds the button_event_gen state encoding, the 25 MHz default tick counts
// and a small helper for sizing counters from parameters.
package pong_pkg;

    // Event generator states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD      = 2'd1,
        ST_REPEAT    = 2'd2,
        ST_LONG_DONE = 2'd3
    } btn_state_t;

    // Default timing at 25 MHz: 1 s long-press, 200 ms auto-repeat
    localparam int unsigned LONG_TICKS_DEFAULT   = 32'd25_000_000;
    localparam int unsigned REPEAT_TICKS_DEFAULT = 32'd5_000_000;

    // Larger of two tick counts, used to size shared counters
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into one-cycle event strobes.
//
// Ports:
//   i_Clk      system clock
//   i_Rst      asynchronous active-high reset
//   i_Switch   debounced button level, 1 = pressed, synchronous to i_Clk
//   o_Press    one-cycle strobe on press
//   o_Release  one-cycle strobe on release
//   o_Long     one-cycle strobe when the hold reaches LONG_TICKS
//   o_Repeat   one-cycle strobe every REPEAT_TICKS after o_Long (REPEAT_EN=1)
//   o_Held     level, high from the o_Press cycle until o_Release
//
// All outputs are registered; an edge sampled at clock N shows up in cycle N+1.
module button_event_gen
    import pong_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = LONG_TICKS_DEFAULT,
    parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEFAULT,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long,
    output logic o_Repeat,
    output logic o_Held
);

    localparam int unsigned MAX_TICKS = max_u(LONG_TICKS, REPEAT_TICKS);
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    btn_state_t       r_State;
    btn_state_t       w_State_Nxt;
    logic [CNT_W-1:0] r_Count;
    logic [CNT_W-1:0] w_Count_Nxt;
    logic [CNT_W-1:0] w_Count_Inc;
    logic             r_Prev;
    logic             w_Rise;
    logic             w_Fall;

    logic r_Press,   w_Press;
    logic r_Release, w_Release;
    logic r_Long,    w_Long;
    logic r_Repeat,  w_Repeat;
    logic r_Held,    w_Held;

    // Edge detection against the previous sample
    assign w_Rise = i_Switch & ~r_Prev;
    assign w_Fall = ~i_Switch & r_Prev;

    // Saturating increment so a stuck counter can never wrap into a false match
    assign w_Count_Inc = (r_Count == CNT_MAX) ? r_Count : r_Count + CNT_W'(1);

    // State, counter, edge history and output registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State   <= ST_IDLE;
            r_Count   <= '0;
            r_Prev    <= 1'b0;
            r_Press   <= 1'b0;
            r_Release <= 1'b0;
            r_Long    <= 1'b0;
            r_Repeat  <= 1'b0;
            r_Held    <= 1'b0;
        end else begin
            r_State   <= w_State_Nxt;
            r_Count   <= w_Count_Nxt;
            r_Prev    <= i_Switch;
            r_Press   <= w_Press;
            r_Release <= w_Release;
            r_Long    <= w_Long;
            r_Repeat  <= w_Repeat;
            r_Held    <= w_Held;
        end
    end

    // Next-state and next-output decode; release takes priority over terminal counts
    always_comb begin
        w_State_Nxt = r_State;
        w_Count_Nxt = r_Count;
        w_Press     = 1'b0;
        w_Release   = 1'b0;
        w_Long      = 1'b0;
        w_Repeat    = 1'b0;

        case (r_State)
            ST_IDLE: begin
                w_Count_Nxt = '0;
                if (w_Rise) begin
                    w_Press     = 1'b1;
                    w_State_Nxt = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (w_Fall) begin
                    w_Release   = 1'b1;
                    w_Count_Nxt = '0;
                    w_State_Nxt = ST_IDLE;
                end else if (r_Count == LONG_LAST) begin
                    w_Long      = 1'b1;
                    w_Count_Nxt = '0;
                    w_State_Nxt = REPEAT_EN ? ST_REPEAT : ST_LONG_DONE;
                end else begin
                    w_Count_Nxt = w_Count_Inc;
                end
            end

            ST_REPEAT: begin
                if (w_Fall) begin
                    w_Release   = 1'b1;
                    w_Count_Nxt = '0;
                    w_State_Nxt = ST_IDLE;
                end else if (r_Count == REPEAT_LAST) begin
                    w_Repeat    = REPEAT_EN;
                    w_Count_Nxt = '0;
                end else begin
                    w_Count_Nxt = w_Count_Inc;
                end
            end

            ST_LONG_DONE: begin
                w_Count_Nxt = '0;
                if (w_Fall) begin
                    w_Release   = 1'b1;
                    w_State_Nxt = ST_IDLE;
                end
            end

            default: begin
                w_Count_Nxt = '0;
                w_State_Nxt = ST_IDLE;
            end
        endcase

        // Held tracks the state being entered, so it drops with o_Release
        w_Held = (w_State_Nxt != ST_IDLE);
    end

    assign o_Press   = r_Press;
    assign o_Release = r_Release;
    assign o_Long    = r_Long;
    assign o_Repeat  = r_Repeat;
    assign o_Held    = r_Held;

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen (LONG_TICKS=10, REPEAT_TICKS=4).
// Instance a has auto-repeat enabled, instance b has it disabled.
module tb_button_event_gen;

    typedef logic [4:0] vec_t; // {press, release, long, repeat, held}

    logic clk = 1'b0;
    logic rst;
    logic sw_a, sw_b;
    logic a_press, a_release, a_long, a_repeat, a_held;
    logic b_press, b_release, b_long, b_repeat, b_held;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb_q[$];

    always #5 clk = ~clk;

    button_event_gen #(.LONG_TICKS(10), .REPEAT_TICKS(4), .REPEAT_EN(1'b1)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Switch(sw_a),
        .o_Press(a_press), .o_Release(a_release), .o_Long(a_long),
        .o_Repeat(a_repeat), .o_Held(a_held)
    );

    button_event_gen #(.LONG_TICKS(10), .REPEAT_TICKS(4), .REPEAT_EN(1'b0)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Switch(sw_b),
        .o_Press(b_press), .o_Release(b_release), .o_Long(b_long),
        .o_Repeat(b_repeat), .o_Held(b_held)
    );

    // Expected outputs after edge k for a hold sampled high on edges p .. p+h-1
    function automatic vec_t exp_win(input int k, input int p, input int h, input bit rep);
        vec_t v;
        v = '0;
        if (h == 0) return v;
        if (k == p)                         v[4] = 1'b1;
        if (k == p + h)                     v[3] = 1'b1;
        if (h > 10 && k == p + 10)          v[2] = 1'b1;
        if (rep && k >= p + 14 && k < p + h && ((k - p - 10) % 4) == 0)
                                            v[1] = 1'b1;
        if (k >= p && k < p + h)            v[0] = 1'b1;
        return v;
    endfunction

    function automatic vec_t obs(input bit use_b);
        if (use_b) return {b_press, b_release, b_long, b_repeat, b_held};
        return {a_press, a_release, a_long, a_repeat, a_held};
    endfunction

    // Leaves the bench at a falling edge with reset released; next rising edge is edge 1
    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b1;
        sw_a = 1'b0;
        sw_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive up to two hold windows and score every cycle against the timeline
    task automatic run_pattern(input string name, input bit use_b,
                               input int p1, input int h1,
                               input int p2, input int h2, input int total);
        vec_t e, o;
        logic s;
        apply_reset();
        for (int k = 1; k <= total; k++) begin
            s = (k >= p1 && k < p1 + h1) || (h2 > 0 && k >= p2 && k < p2 + h2);
            if (use_b) sw_b = s; else sw_a = s;
            sb_q.push_back(exp_win(k, p1, h1, !use_b) | exp_win(k, p2, h2, !use_b));
            @(posedge clk);
            #1;
            o = obs(use_b);
            e = sb_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s edge %0d: got %b expected %b", name, k, o, e);
            end
            @(negedge clk);
        end
        sw_a = 1'b0;
        sw_b = 1'b0;
    endtask

    task automatic test_reset();
        vec_t o;
        @(negedge clk);
        sw_a = 1'b0;
        sw_b = 1'b0;
        #2 rst = 1'b1;
        #1;
        o = obs(1'b0);
        n_checks++;
        if (o !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_a: got %b expected %b", o, 5'b0);
        end
        o = obs(1'b1);
        n_checks++;
        if (o !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_b: got %b expected %b", o, 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_short_press();
        run_pattern("short_press", 1'b0, 5, 6, 0, 0, 16);
    endtask

    task automatic test_long_hold();
        run_pattern("long_hold", 1'b0, 5, 25, 0, 0, 36);
    endtask

    task automatic test_release_at_terminal();
        run_pattern("release_at_long", 1'b0, 5, 10, 0, 0, 20);
        run_pattern("release_at_repeat", 1'b0, 5, 18, 0, 0, 28);
    endtask

    task automatic test_reset_mid_repeat();
        vec_t e, o;
        apply_reset();
        sw_a = 1'b1;
        // Hold until the first repeat strobe (edge 15) is on the outputs
        for (int k = 1; k <= 15; k++) begin
            sb_q.push_back(exp_win(k, 1, 100, 1'b1));
            @(posedge clk);
            #1;
            o = obs(1'b0);
            e = sb_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mid_repeat_hold edge %0d: got %b expected %b", k, o, e);
            end
        end
        // Assert reset between edges: outputs must clear without a clock
        #2 rst = 1'b1;
        #1;
        o = obs(1'b0);
        n_checks++;
        if (o !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b", o, 5'b0);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            o = obs(1'b0);
            n_checks++;
            if (o !== 5'b0) begin
                n_fail++;
                $display("FAIL in_reset cycle %0d: got %b expected %b", k, o, 5'b0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        // Switch still high: treated as a fresh press on the first edge
        for (int k = 1; k <= 12; k++) begin
            sb_q.push_back(exp_win(k, 1, 100, 1'b1));
            @(posedge clk);
            #1;
            o = obs(1'b0);
            e = sb_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL post_reset edge %0d: got %b expected %b", k, o, e);
            end
        end
        @(negedge clk);
        sw_a = 1'b0;
    endtask

    task automatic test_repeat_disabled();
        run_pattern("repeat_disabled", 1'b1, 5, 30, 0, 0, 40);
    endtask

    task automatic test_back_to_back();
        run_pattern("back_to_back", 1'b0, 3, 5, 9, 15, 30);
    endtask

    initial begin
        rst  = 1'b1;
        sw_a = 1'b0;
        sw_b = 1'b0;
        test_reset();
        test_short_press();
        test_long_hold();
        test_release_at_terminal();
        test_reset_mid_repeat();
        test_repeat_disabled();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
